// File: rtl/dwt_pkg.sv
// Shared constants and types for the DAUB-4 DWT stage and its coefficient packer.
package dwt_pkg;

    localparam int unsigned IN_W_DEF     = 32;
    localparam int unsigned IN_FRAC_DEF  = 16;
    localparam int unsigned OUT_W_DEF    = 16;
    localparam int unsigned OUT_FRAC_DEF = 8;
    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned SAT_CNT_W    = 16;

    // Rounding constant for round-half-toward-+inf: half an output LSB in input units
    localparam int unsigned QUANT_SHIFT_DEF = IN_FRAC_DEF - OUT_FRAC_DEF;
    localparam int unsigned QUANT_RND_DEF   = 1 << (QUANT_SHIFT_DEF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_L = 2'd1,
        SEND_H = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/dwt_quant_sat.sv
// Combinational round-half-up and saturate from IN_W.IN_FRAC to OUT_W.OUT_FRAC.
module dwt_quant_sat
    import dwt_pkg::*;
#(
    parameter int unsigned IN_W     = IN_W_DEF,
    parameter int unsigned IN_FRAC  = IN_FRAC_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned OUT_FRAC = OUT_FRAC_DEF
) (
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] q_c,
    output logic             sat_c
);

    localparam int unsigned SHIFT = IN_FRAC - OUT_FRAC;
    localparam int unsigned EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] RND   = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] Q_MAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] Q_MIN = ~Q_MAX;

    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shifted;

    // One extra bit keeps the rounding add from wrapping near the positive limit
    always_comb begin
        sum     = $signed({x[IN_W-1], x}) + RND;
        shifted = sum >>> SHIFT;
        q_c     = shifted[OUT_W-1:0];
        sat_c   = 1'b0;
        if (shifted > Q_MAX) begin
            q_c   = Q_MAX[OUT_W-1:0];
            sat_c = 1'b1;
        end else if (shifted < Q_MIN) begin
            q_c   = Q_MIN[OUT_W-1:0];
            sat_c = 1'b1;
        end
    end

endmodule

// File: rtl/dwt_coef_packer.sv
// Quantises DWT (L,H) pairs, buffers them in a FIFO and streams them out as L then H beats.
module dwt_coef_packer
    import dwt_pkg::*;
#(
    parameter int unsigned IN_W     = IN_W_DEF,
    parameter int unsigned IN_FRAC  = IN_FRAC_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned OUT_FRAC = OUT_FRAC_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_L,
    input  logic [IN_W-1:0]        in_H,
    input  logic                   in_last,
    input  logic                   clear,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_is_h,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [SAT_CNT_W-1:0]   sat_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned ENT_W  = 2 * OUT_W + 1;
    localparam int unsigned HOLD_W = OUT_W + 1;

    logic [OUT_W-1:0]     q_l_c, q_h_c;
    logic                 sat_l_c, sat_h_c;

    logic                 qv_q, qv_d, qlast_q, qlast_d;
    logic [OUT_W-1:0]     ql_q, ql_d, qh_q, qh_d;
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;
    logic                 ovf_q, ovf_d;
    logic [LVL_W-1:0]     wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [ENT_W-1:0]     mem_q [DEPTH];
    logic [ENT_W-1:0]     mem_d [DEPTH];
    fsm_state_e           state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [OUT_W-1:0]     odata_q, odata_d;
    logic                 ois_h_q, ois_h_d, olast_q, olast_d, ovalid_q, ovalid_d;

    logic [LVL_W-1:0]     level;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [ENT_W-1:0]     entry_in, head, next_head, load_ent;
    logic                 full, pop, wr_en, drop, load_en;
    logic [1:0]           sat_inc;
    logic [SAT_CNT_W:0]   sat_sum;

    dwt_quant_sat #(.IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)) u_quant_l (
        .x(in_L), .q_c(q_l_c), .sat_c(sat_l_c)
    );

    dwt_quant_sat #(.IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC)) u_quant_h (
        .x(in_H), .q_c(q_h_c), .sat_c(sat_h_c)
    );

    // Quantiser stage, clip counter and sticky overflow; clear beats any same-cycle event
    always_comb begin
        qv_d    = in_valid;
        ql_d    = q_l_c;
        qh_d    = q_h_c;
        qlast_d = in_last;
        sat_inc = 2'(sat_l_c) + 2'(sat_h_c);
        sat_sum = (SAT_CNT_W + 1)'(sat_cnt_q) + (SAT_CNT_W + 1)'(sat_inc);
        sat_cnt_d = sat_cnt_q;
        if (clear) begin
            sat_cnt_d = '0;
        end else if (in_valid) begin
            sat_cnt_d = sat_sum[SAT_CNT_W] ? {SAT_CNT_W{1'b1}} : sat_sum[SAT_CNT_W-1:0];
        end
        ovf_d = clear ? 1'b0 : (ovf_q | drop);
    end

    // FIFO bookkeeping: a full FIFO still accepts a pair when the head pops the same cycle
    always_comb begin
        level     = wr_cnt_q - rd_cnt_q;
        wr_ptr    = wr_cnt_q[PTR_W-1:0];
        rd_ptr    = rd_cnt_q[PTR_W-1:0];
        full      = (level == LVL_W'(DEPTH));
        pop       = (state_q == SEND_H) && out_ready;
        wr_en     = qv_q && (!full || pop);
        drop      = qv_q && !wr_en;
        entry_in  = {qlast_q, ql_q, qh_q};
        head      = mem_q[rd_ptr];
        next_head = mem_q[PTR_W'(rd_ptr + PTR_W'(1))];
        wr_cnt_d  = wr_cnt_q + LVL_W'(wr_en);
        rd_cnt_d  = rd_cnt_q + LVL_W'(pop);
        mem_d     = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = entry_in;
        end
    end

    // Output FSM; a fresh pair bypasses straight from the quantiser stage when nothing is queued
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        odata_d  = odata_q;
        ois_h_d  = ois_h_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q;
        load_en  = 1'b0;
        load_ent = head;
        unique case (state_q)
            IDLE: begin
                if (level != '0) begin
                    load_en  = 1'b1;
                    load_ent = head;
                end else if (wr_en) begin
                    load_en  = 1'b1;
                    load_ent = entry_in;
                end
            end
            SEND_L: begin
                if (out_ready) begin
                    odata_d = hold_q[OUT_W-1:0];
                    ois_h_d = 1'b1;
                    olast_d = hold_q[HOLD_W-1];
                    state_d = SEND_H;
                end
            end
            SEND_H: begin
                if (out_ready) begin
                    if (level > LVL_W'(1)) begin
                        load_en  = 1'b1;
                        load_ent = next_head;
                    end else if (wr_en) begin
                        load_en  = 1'b1;
                        load_ent = entry_in;
                    end else begin
                        state_d  = IDLE;
                        odata_d  = '0;
                        ois_h_d  = 1'b0;
                        olast_d  = 1'b0;
                        ovalid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_en) begin
            hold_d   = {load_ent[ENT_W-1], load_ent[OUT_W-1:0]};
            odata_d  = load_ent[2*OUT_W-1:OUT_W];
            ois_h_d  = 1'b0;
            olast_d  = 1'b0;
            ovalid_d = 1'b1;
            state_d  = SEND_L;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            qv_q      <= 1'b0;
            ql_q      <= '0;
            qh_q      <= '0;
            qlast_q   <= 1'b0;
            sat_cnt_q <= '0;
            ovf_q     <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            state_q   <= IDLE;
            hold_q    <= '0;
            odata_q   <= '0;
            ois_h_q   <= 1'b0;
            olast_q   <= 1'b0;
            ovalid_q  <= 1'b0;
        end else begin
            qv_q      <= qv_d;
            ql_q      <= ql_d;
            qh_q      <= qh_d;
            qlast_q   <= qlast_d;
            sat_cnt_q <= sat_cnt_d;
            ovf_q     <= ovf_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            odata_q   <= odata_d;
            ois_h_q   <= ois_h_d;
            olast_q   <= olast_d;
            ovalid_q  <= ovalid_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_data   = odata_q;
    assign out_is_h   = ois_h_q;
    assign out_last   = olast_q;
    assign out_valid  = ovalid_q;
    assign overflow   = ovf_q;
    assign sat_count  = sat_cnt_q;
    assign fifo_level = level;

endmodule
